// File: rtl/icache_responder_if.sv
// Line-fill bus between the instruction cache and its backing memory.
// The cache is the master, and the memory model or controller is the slave.
interface icache_responder_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache for the fetch stage.
// It returns a hit with zero latency and stalls fetch while it refills a line.
module icache_responder #(
  parameter int          NUM_LINES  = 8,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        imem_stall,
  input  logic        inval,
  icache_responder_if.master mem
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = OFF_W + IDX_W + 2;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e               state_q, state_d;
  logic [OFF_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [31:0]          addr_q, addr_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 data_we, tag_we;

  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             hit;
  logic             unused_pc_bits;

  assign pc_off         = pcF[OFF_W+1:2];
  assign pc_idx         = pcF[TAG_LSB-1:OFF_W+2];
  assign pc_tag         = pcF[31:TAG_LSB];
  assign fill_idx       = addr_q[TAG_LSB-1:OFF_W+2];
  assign fill_tag       = addr_q[31:TAG_LSB];
  assign unused_pc_bits = ^pcF[1:0];

  // Hits are only served from IDLE, so a line being refilled is never read half-written.
  assign hit        = (state_q == IDLE) && valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign instrF     = hit ? data_mem[{pc_idx, pc_off}] : NOP_INSTR;
  assign imem_stall = !hit;

  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inval) valid_d = '0;
        if (!hit) begin
          state_d = REQ;
          addr_d  = {pcF[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
      end
      REQ: begin
        if (inval) pend_d = 1'b1;
        if (mem.mem_gnt) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (inval) pend_d = 1'b1;
        if (mem.mem_rvalid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = IDLE;
            tag_we  = 1'b1;
            // An invalidate seen at any point during the fill, including this edge, wipes everything.
            if (pend_q || inval) begin
              valid_d = '0;
              pend_d  = 1'b0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // The storage arrays are not reset, because the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk) begin
    if (!rst && data_we) data_mem[{fill_idx, cnt_q}] <= mem.mem_rdata;
    if (!rst && tag_we)  tag_mem[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_responder.sv
// Directed, table-driven bench for icache_responder.
// Each row applies one cycle of inputs and checks the outputs on the falling edge.
module tb_icache_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] NA  = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        imem_stall;
  logic        inval;

  icache_responder_if mem_if ();

  icache_responder #(
    .NUM_LINES (8),
    .LINE_WORDS(4),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pcF       (pcF),
    .instrF    (instrF),
    .imem_stall(imem_stall),
    .inval     (inval),
    .mem       (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        inv;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rs;
    logic        stall;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic [31:0] pc, logic inv, logic gnt, logic rv, logic [31:0] rdata,
                              logic rs, logic stall, logic [31:0] instr, logic req, logic [31:0] addr);
    vec_t v;
    v.pc = pc; v.inv = inv; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rs = rs;
    v.stall = stall; v.instr = instr; v.req = req; v.addr = addr;
    return v;
  endfunction

  function automatic vec_t miss(logic [31:0] pc);
    return mk(pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0, NA);
  endfunction
  function automatic vec_t rq(logic [31:0] pc, logic gnt, logic rv, logic [31:0] rdata, logic [31:0] addr);
    return mk(pc, 1'b0, gnt, rv, rdata, 1'b0, 1'b1, NOP, 1'b1, addr);
  endfunction
  function automatic vec_t bt(logic [31:0] pc, logic rv, logic [31:0] rdata, logic inv);
    return mk(pc, inv, 1'b0, rv, rdata, 1'b0, 1'b1, NOP, 1'b0, NA);
  endfunction
  function automatic vec_t hit(logic [31:0] pc, logic inv, logic [31:0] instr);
    return mk(pc, inv, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, instr, 1'b0, NA);
  endfunction

  task automatic step(input vec_t v, input string name, input int idx);
    rst               = v.rs;
    pcF               = v.pc;
    inval             = v.inv;
    mem_if.mem_gnt    = v.gnt;
    mem_if.mem_rvalid = v.rv;
    mem_if.mem_rdata  = v.rdata;
    @(negedge clk);
    n_cmp++;
    if (imem_stall !== v.stall) begin
      n_fail++;
      $display("FAIL %s[%0d] imem_stall: got %0b want %0b (pc=%h)", name, idx, imem_stall, v.stall, v.pc);
    end
    n_cmp++;
    if (instrF !== v.instr) begin
      n_fail++;
      $display("FAIL %s[%0d] instrF: got %h want %h (pc=%h)", name, idx, instrF, v.instr, v.pc);
    end
    n_cmp++;
    if (mem_if.mem_req !== v.req) begin
      n_fail++;
      $display("FAIL %s[%0d] mem_req: got %0b want %0b", name, idx, mem_if.mem_req, v.req);
    end
    if (v.addr !== NA) begin
      n_cmp++;
      if (mem_if.mem_addr !== v.addr) begin
        n_fail++;
        $display("FAIL %s[%0d] mem_addr: got %h want %h", name, idx, mem_if.mem_addr, v.addr);
      end
    end
    $display("%s[%0d] pc=%h inv=%0b gnt=%0b rv=%0b -> stall=%0b instr=%h req=%0b addr=%h",
             name, idx, v.pc, v.inv, v.gnt, v.rv, imem_stall, instrF, mem_if.mem_req, mem_if.mem_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pcF = '0; inval = 1'b0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    step(mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, NOP, 1'b0, 32'h0), "reset", 0);

    // Cold miss with no wait states: the hit lands six cycles after the miss.
    tbl.push_back(mk(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0, 32'h0));
    tbl.push_back(rq(32'h0, 1'b1, 1'b0, 32'h0, 32'h0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA0, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA1, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA2, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA3, 1'b0));
    tbl.push_back(hit(32'h0, 1'b0, 32'hA0));
    tbl.push_back(hit(32'hC, 1'b0, 32'hA3));
    tbl.push_back(hit(32'h4, 1'b0, 32'hA1));

    // Late grant with gapped beats; a stray rvalid during REQ must be ignored.
    tbl.push_back(miss(32'h40));
    tbl.push_back(rq(32'h40, 1'b0, 1'b1, 32'hDEAD, 32'h40));
    tbl.push_back(rq(32'h40, 1'b0, 1'b0, 32'h0, 32'h40));
    tbl.push_back(rq(32'h40, 1'b0, 1'b0, 32'h0, 32'h40));
    tbl.push_back(rq(32'h40, 1'b1, 1'b0, 32'h0, 32'h40));
    tbl.push_back(bt(32'h40, 1'b1, 32'hB0, 1'b0));
    tbl.push_back(bt(32'h40, 1'b0, 32'h0, 1'b0));
    tbl.push_back(bt(32'h40, 1'b1, 32'hB1, 1'b0));
    tbl.push_back(bt(32'h40, 1'b0, 32'h0, 1'b0));
    tbl.push_back(bt(32'h40, 1'b0, 32'h0, 1'b0));
    tbl.push_back(bt(32'h40, 1'b1, 32'hB2, 1'b0));
    tbl.push_back(bt(32'h40, 1'b0, 32'h0, 1'b0));
    tbl.push_back(bt(32'h40, 1'b1, 32'hB3, 1'b0));
    tbl.push_back(hit(32'h40, 1'b0, 32'hB0));
    tbl.push_back(hit(32'h48, 1'b0, 32'hB2));
    tbl.push_back(hit(32'h4C, 1'b0, 32'hB3));
    tbl.push_back(hit(32'h44, 1'b0, 32'hB1));
    tbl.push_back(hit(32'h0, 1'b0, 32'hA0));

    // Conflict eviction: 0x80 shares line 0 with 0x0.
    tbl.push_back(miss(32'h80));
    tbl.push_back(rq(32'h80, 1'b1, 1'b0, 32'h0, 32'h80));
    tbl.push_back(bt(32'h80, 1'b1, 32'hC0, 1'b0));
    tbl.push_back(bt(32'h80, 1'b1, 32'hC1, 1'b0));
    tbl.push_back(bt(32'h80, 1'b1, 32'hC2, 1'b0));
    tbl.push_back(bt(32'h80, 1'b1, 32'hC3, 1'b0));
    tbl.push_back(hit(32'h80, 1'b0, 32'hC0));
    tbl.push_back(hit(32'h84, 1'b0, 32'hC1));
    tbl.push_back(miss(32'h0));
    tbl.push_back(rq(32'h0, 1'b1, 1'b0, 32'h0, 32'h0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA0, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA1, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA2, 1'b0));
    tbl.push_back(bt(32'h0, 1'b1, 32'hA3, 1'b0));
    tbl.push_back(hit(32'h8, 1'b0, 32'hA2));

    // Redirect mid-fill. The target 0x210 uses line 1, so the completed 0x100 line survives.
    tbl.push_back(miss(32'h100));
    tbl.push_back(rq(32'h100, 1'b1, 1'b0, 32'h0, 32'h100));
    tbl.push_back(bt(32'h100, 1'b1, 32'hD0, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hD1, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hD2, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hD3, 1'b0));
    tbl.push_back(miss(32'h210));
    tbl.push_back(rq(32'h210, 1'b1, 1'b0, 32'h0, 32'h210));
    tbl.push_back(bt(32'h210, 1'b1, 32'hE0, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hE1, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hE2, 1'b0));
    tbl.push_back(bt(32'h210, 1'b1, 32'hE3, 1'b0));
    tbl.push_back(hit(32'h210, 1'b0, 32'hE0));
    tbl.push_back(hit(32'h100, 1'b0, 32'hD0));
    tbl.push_back(hit(32'h10C, 1'b0, 32'hD3));

    // Invalidate during a fill wipes every line, including the one just filled.
    tbl.push_back(miss(32'h60));
    tbl.push_back(rq(32'h60, 1'b1, 1'b0, 32'h0, 32'h60));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF0, 1'b1));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF1, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF2, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF3, 1'b0));
    tbl.push_back(miss(32'h100));
    tbl.push_back(rq(32'h100, 1'b1, 1'b0, 32'h0, 32'h100));
    tbl.push_back(bt(32'h100, 1'b1, 32'hD0, 1'b0));
    tbl.push_back(bt(32'h100, 1'b1, 32'hD1, 1'b0));
    tbl.push_back(bt(32'h100, 1'b1, 32'hD2, 1'b0));
    tbl.push_back(bt(32'h100, 1'b1, 32'hD3, 1'b0));
    tbl.push_back(hit(32'h100, 1'b0, 32'hD0));
    // An invalidate in IDLE still hits in the pulse cycle and misses in the following cycle.
    tbl.push_back(hit(32'h104, 1'b1, 32'hD1));
    tbl.push_back(miss(32'h104));
    tbl.push_back(rq(32'h104, 1'b1, 1'b0, 32'h0, 32'h100));
    tbl.push_back(bt(32'h104, 1'b1, 32'h70, 1'b0));
    tbl.push_back(bt(32'h104, 1'b1, 32'h71, 1'b0));
    tbl.push_back(bt(32'h104, 1'b1, 32'h72, 1'b0));
    tbl.push_back(bt(32'h104, 1'b1, 32'h73, 1'b0));
    tbl.push_back(hit(32'h104, 1'b0, 32'h71));

    // An invalidate on the completion edge itself also counts.
    tbl.push_back(miss(32'h60));
    tbl.push_back(rq(32'h60, 1'b1, 1'b0, 32'h0, 32'h60));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF0, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF1, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF2, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF3, 1'b1));
    tbl.push_back(miss(32'h60));
    tbl.push_back(rq(32'h60, 1'b1, 1'b0, 32'h0, 32'h60));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF0, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF1, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF2, 1'b0));
    tbl.push_back(bt(32'h60, 1'b1, 32'hF3, 1'b0));
    tbl.push_back(hit(32'h68, 1'b0, 32'hF2));
    // The line at 0x100 was cleared by that invalidate; start a fill that reset will cut short.
    tbl.push_back(miss(32'h104));
    tbl.push_back(rq(32'h104, 1'b1, 1'b0, 32'h0, 32'h100));
    tbl.push_back(bt(32'h104, 1'b1, 32'h90, 1'b0));
    tbl.push_back(bt(32'h104, 1'b1, 32'h91, 1'b0));

    foreach (tbl[i]) step(tbl[i], "vec", i);

    // Reset after two beats, while a third beat arrives on the reset edge.
    step(mk(32'h104, 1'b0, 1'b0, 1'b1, 32'h92, 1'b1, 1'b1, NOP, 1'b0, NA), "rstfill", 0);
    step(mk(32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, NOP, 1'b0, 32'h0), "rstfill", 1);
    step(rq(32'h104, 1'b0, 1'b1, 32'h93, 32'h100), "rstfill", 2);
    step(rq(32'h104, 1'b1, 1'b0, 32'h0, 32'h100), "rstfill", 3);
    step(bt(32'h104, 1'b1, 32'h50, 1'b0), "rstfill", 4);
    step(bt(32'h104, 1'b1, 32'h51, 1'b0), "rstfill", 5);
    step(bt(32'h104, 1'b1, 32'h52, 1'b0), "rstfill", 6);
    step(bt(32'h104, 1'b1, 32'h53, 1'b0), "rstfill", 7);
    step(hit(32'h100, 1'b0, 32'h50), "rstfill", 8);
    step(hit(32'h104, 1'b0, 32'h51), "rstfill", 9);
    step(hit(32'h10C, 1'b0, 32'h53), "rstfill", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
